// File: rtl/bin_maxpool_stage_pkg.sv
// Shared encodings for the binary max-pool stage: one-hot FSM states and header fields.
package bin_maxpool_stage_pkg;

  localparam int                 HDR_W_W  = 8;
  localparam logic [HDR_W_W-1:0] HDR_TERM = 8'hFF;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_HDR_REQ = 6'b000010,
    S_HDR_CAP = 6'b000100,
    S_ROW_A   = 6'b001000,
    S_ROW_B   = 6'b010000,
    S_ROW_W   = 6'b100000
  } state_e;

endpackage

// File: rtl/bin_maxpool_stage_if.sv
// Control and SRAM port bundle of the max-pool stage; master = pool stage, slave = SRAM/controller side.
interface bin_maxpool_stage_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] pool_sram_read_address;
  logic [DATA_W-1:0] sram_pool_read_data;
  logic [ADDR_W-1:0] pool_sram_write_address;
  logic [DATA_W-1:0] pool_sram_write_data;
  logic              pool_sram_write_enable;

  modport master (
    input  dut_run, sram_pool_read_data,
    output dut_busy, pool_sram_read_address,
           pool_sram_write_address, pool_sram_write_data, pool_sram_write_enable
  );

  modport slave (
    output dut_run, sram_pool_read_data,
    input  dut_busy, pool_sram_read_address,
           pool_sram_write_address, pool_sram_write_data, pool_sram_write_enable
  );
endinterface

// File: rtl/bin_maxpool_stage_pool_row_or.sv
// pool_row_or: folds a pair of binary rows into one pooled row, out[j] = OR of the 2x2 window;
// columns at or beyond wo are forced to zero.
module bin_maxpool_stage_pool_row_or
  import bin_maxpool_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]  ra,
  input  logic [DATA_W-1:0]  rb,
  input  logic [HDR_W_W-1:0] wo,
  output logic [DATA_W-1:0]  o
);
  localparam int OUT_W = DATA_W / 2;

  for (genvar j = 0; j < OUT_W; j++) begin : g_col
    assign o[j] = (wo > HDR_W_W'(j)) & (ra[2*j] | ra[2*j+1] | rb[2*j] | rb[2*j+1]);
  end

  assign o[DATA_W-1:OUT_W] = '0;
endmodule

// File: rtl/bin_maxpool_stage.sv
// Binary 2x2/stride-2 max-pool over a header-delimited list of feature maps in SRAM.
// Three cycles per output row: issue row 2k, issue row 2k+1 + latch 2k, OR the pair + write.
module bin_maxpool_stage
  import bin_maxpool_stage_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] IN_BASE  = 12'h000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 12'h200
) (
  input  logic                 clk,
  input  logic                 reset_b,
  bin_maxpool_stage_if.master  bus
);
  localparam logic [HDR_W_W-1:0] W_MAX = HDR_W_W'(DATA_W);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   rd_ptr, rd_ptr_d, row_ptr, row_ptr_d, wr_ptr, wr_ptr_d;
  logic [HDR_W_W-1:0]  w_q, w_d, wo_q, wo_d, k_q, k_d;
  logic [DATA_W-1:0]   ra, ra_d, pooled;
  logic                busy_q, busy_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [HDR_W_W-1:0]  hdr_w, hdr_wo;
  logic                hdr_term, last_row;

  assign hdr_w    = bus.sram_pool_read_data[HDR_W_W-1:0];
  assign hdr_wo   = hdr_w >> 1;
  assign hdr_term = (hdr_w == '0) || (hdr_w == HDR_TERM) || (hdr_w > W_MAX);
  assign last_row = (k_q == wo_q - HDR_W_W'(1));

  // Row 2k+1 is consumed straight off the read bus during ROW_W.
  bin_maxpool_stage_pool_row_or #(.DATA_W(DATA_W)) u_or (
    .ra (ra),
    .rb (bus.sram_pool_read_data),
    .wo (wo_q),
    .o  (pooled)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (bus.dut_run) state_d = S_HDR_REQ;
      S_HDR_REQ: state_d = S_HDR_CAP;
      S_HDR_CAP: begin
        if (hdr_term)            state_d = S_IDLE;
        else if (hdr_wo == '0)   state_d = S_HDR_REQ;
        else                     state_d = S_ROW_A;
      end
      S_ROW_A:   state_d = S_ROW_B;
      S_ROW_B:   state_d = S_ROW_W;
      S_ROW_W:   state_d = last_row ? S_HDR_REQ : S_ROW_A;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = busy_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_ptr_d  = rd_ptr;
    row_ptr_d = row_ptr;
    wr_ptr_d  = wr_ptr;
    w_d       = w_q;
    wo_d      = wo_q;
    k_d       = k_q;
    ra_d      = ra;
    case (state)
      S_IDLE: begin
        // Every accepted run walks the list from the top.
        if (bus.dut_run) begin
          busy_d   = 1'b1;
          rd_ptr_d = IN_BASE;
          wr_ptr_d = OUT_BASE;
        end
      end
      S_HDR_REQ: rd_addr_d = rd_ptr;
      S_HDR_CAP: begin
        if (hdr_term) begin
          busy_d = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr;
          wr_data_d = DATA_W'(hdr_wo);
          wr_ptr_d  = wr_ptr + ADDR_W'(1);
          w_d       = hdr_w;
          wo_d      = hdr_wo;
          k_d       = '0;
          row_ptr_d = rd_ptr + ADDR_W'(1);
          if (hdr_wo == '0) rd_ptr_d = rd_ptr + ADDR_W'(hdr_w) + ADDR_W'(1);
        end
      end
      S_ROW_A: begin
        rd_addr_d = row_ptr;
        row_ptr_d = row_ptr + ADDR_W'(1);
      end
      S_ROW_B: begin
        rd_addr_d = row_ptr;
        row_ptr_d = row_ptr + ADDR_W'(1);
        ra_d      = bus.sram_pool_read_data;
      end
      S_ROW_W: begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr;
        wr_data_d = pooled;
        wr_ptr_d  = wr_ptr + ADDR_W'(1);
        // Skip by W, not by rows consumed: an odd map leaves its last row unread.
        if (last_row) rd_ptr_d = rd_ptr + ADDR_W'(w_q) + ADDR_W'(1);
        else          k_d      = k_q + HDR_W_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_ptr    <= IN_BASE;
      row_ptr   <= '0;
      wr_ptr    <= OUT_BASE;
      w_q       <= '0;
      wo_q      <= '0;
      k_q       <= '0;
      ra        <= '0;
    end else begin
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_ptr    <= rd_ptr_d;
      row_ptr   <= row_ptr_d;
      wr_ptr    <= wr_ptr_d;
      w_q       <= w_d;
      wo_q      <= wo_d;
      k_q       <= k_d;
      ra        <= ra_d;
    end
  end

  assign bus.dut_busy                = busy_q;
  assign bus.pool_sram_read_address  = rd_addr_q;
  assign bus.pool_sram_write_address = wr_addr_q;
  assign bus.pool_sram_write_data    = wr_data_q;
  assign bus.pool_sram_write_enable  = wr_en_q;

endmodule
